pixel_plot_sink: RTL and testbench

// - Receiving end of the pixel-plot interface driven by the game's screen updater: accepts
//   (x, y, colour) plot commands over a valid/ready handshake and buffers them in a small FIFO.
// - Drains accepted commands into the single-port framebuffer RAM, one write per cycle.
// - Provides a full-screen clear command; the menu/game controller issues it on state changes.

---
 rtl/josh_pkg.sv | 28 ++
 rtl/plot_fifo.sv | 59 +++++
 rtl/pixel_plot_sink.sv | 123 ++++++++++++
 tb/tb_pixel_plot_sink.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/josh_pkg.sv
// Shared constants and state encoding for the pixel-plot sink and its framebuffer interface.
package josh_pkg;

    localparam int H_RES      = 160;
    localparam int V_RES      = 120;
    localparam int X_W        = 8;
    localparam int Y_W        = 7;
    localparam int COL_W      = 3;
    localparam int ADDR_W     = 15;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_W     = X_W + Y_W + COL_W;

    localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
    localparam logic [COL_W-1:0] COL_BLUE  = 3'b001;
    localparam logic [COL_W-1:0] COL_GREEN = 3'b010;
    localparam logic [COL_W-1:0] COL_RED   = 3'b100;
    localparam logic [COL_W-1:0] COL_WHITE = 3'b111;

    localparam logic [COL_W-1:0] CLEAR_COLOUR = COL_BLACK;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous command FIFO; the head entry is visible on rdata whenever empty is low.
module plot_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_plot_sink.sv
// Accepts (x, y, colour) plot commands, buffers them, and writes them into the framebuffer;
// also sweeps the whole screen to CLEAR_COLOUR on request.
module pixel_plot_sink
    import josh_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              plot_valid,
    output logic              plot_ready,
    input  logic [X_W-1:0]    plot_x,
    input  logic [Y_W-1:0]    plot_y,
    input  logic [COL_W-1:0]  plot_colour,
    input  logic              clear_req,
    output logic              clear_done,
    output logic              busy,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [COL_W-1:0]  fb_wdata,
    output logic [7:0]        oob_count,
    output state_t            state_dbg
);

    localparam logic [X_W-1:0]    X_LIM   = X_W'(H_RES);
    localparam logic [Y_W-1:0]    Y_LIM   = Y_W'(V_RES);
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(H_RES * V_RES - 1);

    state_t              state;
    logic [FIFO_W-1:0]   fifo_wdata;
    logic [FIFO_W-1:0]   fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [X_W-1:0]      head_x;
    logic [Y_W-1:0]      head_y;
    logic [COL_W-1:0]    head_colour;
    logic [ADDR_W-1:0]   head_addr;
    logic                in_range;

    // Handshake: a command transfers on a rising clk edge where plot_valid && plot_ready;
    // plot_valid may be withdrawn without a transfer, and plot_ready never depends on plot_valid.
    assign plot_ready = !fifo_full && (state == RUN);
    assign push       = plot_valid && plot_ready;
    assign pop        = !fifo_empty && ((state == RUN) || (state == WAIT));
    assign fifo_wdata = {plot_x, plot_y, plot_colour};

    assign head_x      = fifo_rdata[FIFO_W-1 -: X_W];
    assign head_y      = fifo_rdata[COL_W +: Y_W];
    assign head_colour = fifo_rdata[COL_W-1:0];
    assign head_addr   = ADDR_W'(head_y) * ADDR_W'(H_RES) + ADDR_W'(head_x);
    assign in_range    = (head_x < X_LIM) && (head_y < Y_LIM);

    assign busy      = !fifo_empty || fb_we || (state != RUN);
    assign state_dbg = state;

    plot_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
            clear_done <= 1'b0;
            oob_count  <= '0;
        end else begin
            fb_we      <= 1'b0;
            clear_done <= 1'b0;
            if (pop && !in_range && (oob_count != 8'hFF)) begin
                oob_count <= oob_count + 8'd1;
            end
            if (pop && in_range) begin
                fb_we    <= 1'b1;
                fb_addr  <= head_addr;
                fb_wdata <= head_colour;
            end
            case (state)
                RUN: begin
                    if (clear_req) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // Sweep starts only once every queued plot has reached the framebuffer.
                    if (fifo_empty && !fb_we) begin
                        state    <= CLEAR;
                        fb_we    <= 1'b1;
                        fb_addr  <= '0;
                        fb_wdata <= CLEAR_COLOUR;
                    end
                end
                CLEAR: begin
                    if (fb_addr == FB_LAST) begin
                        state      <= DONE;
                        clear_done <= 1'b1;
                    end else begin
                        fb_we   <= 1'b1;
                        fb_addr <= fb_addr + 1'b1;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Directed bench for pixel_plot_sink: plots, back-to-back flow, out-of-range drops,
// full clear, reset mid-clear, and randomly stalled valid.
module tb_pixel_plot_sink;
    import josh_pkg::*;

    logic              clk;
    logic              reset;
    logic              plot_valid;
    logic              plot_ready;
    logic [X_W-1:0]    plot_x;
    logic [Y_W-1:0]    plot_y;
    logic [COL_W-1:0]  plot_colour;
    logic              clear_req;
    logic              clear_done;
    logic              busy;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [COL_W-1:0]  fb_wdata;
    logic [7:0]        oob_count;
    state_t            state_dbg;

    logic [ADDR_W+COL_W-1:0] exp_q[$];
    int check_count = 0;
    int error_count = 0;
    int wr_seen     = 0;
    int done_cnt    = 0;
    int clr_exp_addr = 0;

    pixel_plot_sink dut (
        .clk         (clk),
        .reset       (reset),
        .plot_valid  (plot_valid),
        .plot_ready  (plot_ready),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .clear_req   (clear_req),
        .clear_done  (clear_done),
        .busy        (busy),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .oob_count   (oob_count),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: holds one command until it transfers, recording the expected write
    task automatic send(input int x, input int y, input int c);
        logic acc;
        int   n;
        logic [ADDR_W-1:0] a;
        plot_x      = X_W'(x);
        plot_y      = Y_W'(y);
        plot_colour = COL_W'(c);
        plot_valid  = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            acc = plot_ready;
            if (acc && x < 160 && y < 120) begin
                a = ADDR_W'(y * 160 + x);
                exp_q.push_back({a, COL_W'(c)});
            end
            tick();
            n++;
        end
        plot_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    // scoreboard: pixel writes come from exp_q in order; otherwise a clear write is expected
    always @(negedge clk) begin
        if (!reset) begin
            if (clear_done) done_cnt++;
            if (fb_we) begin
                wr_seen++;
                if (exp_q.size() > 0) begin
                    check("pixel_write", 32'({fb_addr, fb_wdata}), 32'(exp_q.pop_front()));
                end else begin
                    check("clear_write", 32'({fb_addr, fb_wdata}),
                          32'({ADDR_W'(clr_exp_addr), 3'b000}));
                    clr_exp_addr++;
                end
            end
        end
    end

    initial begin
        int n;
        int w0;
        int d0;
        int viol;
        int acc_n;
        reset       = 1'b1;
        plot_valid  = 1'b0;
        plot_x      = '0;
        plot_y      = '0;
        plot_colour = '0;
        clear_req   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_wdata", 32'(fb_wdata), 32'd0);
        check("rst_clear_done", 32'(clear_done), 32'd0);
        check("rst_oob", 32'(oob_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(plot_ready), 32'd1);
        check("rst_state", 32'(state_dbg), 32'(RUN));

        // single plot latency
        send(5, 2, 5);
        check("lat_we_early", 32'(fb_we), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        tick();
        check("lat_we", 32'(fb_we), 32'd1);
        check("lat_addr", 32'(fb_addr), 32'd325);
        check("lat_data", 32'(fb_wdata), 32'd5);
        tick();
        check("lat_idle", 32'(busy), 32'd0);

        // six back-to-back plots, written on consecutive cycles
        for (int i = 0; i < 6; i++) begin
            check("b2b_ready", 32'(plot_ready), 32'd1);
            send(10 * i + 3, 100 + i, i + 1);
            if (i >= 1) check("b2b_we", 32'(fb_we), 32'd1);
        end
        tick();
        check("b2b_we_last", 32'(fb_we), 32'd1);
        tick();
        check("b2b_we_end", 32'(fb_we), 32'd0);
        check("b2b_queue", 32'(exp_q.size()), 32'd0);

        // out-of-range commands are dropped and counted
        w0 = wr_seen;
        send(160, 0, 7);
        send(0, 120, 7);
        repeat (4) tick();
        check("oob_no_write", 32'(wr_seen - w0), 32'd0);
        check("oob_two", 32'(oob_count), 32'd2);
        for (int i = 0; i < 298; i++) send(160 + (i % 96), i % 128, 7);
        repeat (4) tick();
        check("oob_sat", 32'(oob_count), 32'd255);
        check("oob_no_write2", 32'(wr_seen - w0), 32'd0);

        // three plots then a clear requested alongside the third transfer
        clr_exp_addr = 0;
        d0 = done_cnt;
        send(1, 1, 1);
        send(2, 2, 2);
        clear_req = 1'b1;
        send(3, 3, 3);
        clear_req = 1'b0;
        n = 0;
        viol = 0;
        while (n < 25000) begin
            if (state_dbg == RUN) break;
            if (plot_ready) viol++;
            tick();
            n++;
        end
        check("clr_timeout", 32'(n < 25000), 32'd1);
        check("clr_ready_low", 32'(viol), 32'd0);
        check("clr_count", 32'(clr_exp_addr), 32'd19200);
        check("clr_done_once", 32'(done_cnt - d0), 32'd1);
        check("clr_pixels", 32'(exp_q.size()), 32'd0);
        tick();
        check("clr_idle", 32'(busy), 32'd0);

        // reset in the middle of a clear sweep
        clr_exp_addr = 0;
        d0 = done_cnt;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (n < 2000 && !(fb_we && fb_addr == 15'd1000)) begin
            tick();
            n++;
        end
        check("mid_reach", 32'(n < 2000), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_we", 32'(fb_we), 32'd0);
        check("mid_state", 32'(state_dbg), 32'(RUN));
        check("mid_ready", 32'(plot_ready), 32'd1);
        reset = 1'b0;
        repeat (50) tick();
        check("mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_quiet", 32'(fb_we), 32'd0);
        check("mid_oob_rst", 32'(oob_count), 32'd0);

        // randomly stalled valid with fixed data
        clr_exp_addr = 0;
        w0 = wr_seen;
        acc_n = 0;
        plot_x      = 8'd10;
        plot_y      = 7'd20;
        plot_colour = 3'd6;
        for (int i = 0; i < 60; i++) begin
            plot_valid = 1'($urandom_range(0, 1));
            if (plot_valid && plot_ready) begin
                acc_n++;
                exp_q.push_back({ADDR_W'(3210), 3'd6});
            end
            tick();
        end
        plot_valid = 1'b0;
        repeat (6) tick();
        check("stall_writes", 32'(wr_seen - w0), 32'(acc_n));
        check("stall_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
